// File: rtl/xadc_drp_pkg.sv
// Shared types and constants for the XADC DRP arbiter slice.
package xadc_drp_pkg;

    localparam int DRP_AW = 7;
    localparam int DRP_DW = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_GAP   = 2'd3
    } drp_state_e;

    localparam logic [DRP_AW-1:0] XADC_ADDR_TEMP   = 7'h00;
    localparam logic [DRP_AW-1:0] XADC_ADDR_VCCINT = 7'h01;
    localparam logic [DRP_AW-1:0] XADC_ADDR_VCCAUX = 7'h02;
    localparam logic [DRP_AW-1:0] XADC_ADDR_CFG0   = 7'h40;
    localparam logic [DRP_AW-1:0] XADC_ADDR_CFG1   = 7'h41;

    localparam logic [DRP_DW-1:0] XADC_TIMEOUT_DATA = 16'hFFFF;

endpackage

// File: rtl/xadc_rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr_i, wrapping.
module xadc_rr_pick #(
    parameter int NREQ = 3,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [PW-1:0]   idx_o,
    output logic            valid_o
);

    int            cand;
    logic [PW-1:0] candIdx;

    // Scan from the farthest offset down so the nearest hit is written last.
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = 0;
        candIdx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand    = (int'(ptr_i) + k) % NREQ;
            candIdx = PW'(cand);
            if (req_i[candIdx]) begin
                idx_o   = candIdx;
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/xadc_drp_arbiter.sv
// Round-robin arbiter sequencing DRP transactions from NREQ requesters onto one XADC port.
// Optional abort of stalled transactions: define XADC_DRP_TIMEOUT_EN.
module xadc_drp_arbiter
    import xadc_drp_pkg::*;
#(
    parameter int NREQ        = 3,
    parameter int TIMEOUT_CYC = 63
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_i,
    input  logic [NREQ-1:0]        req_we_i,
    input  logic [DRP_AW*NREQ-1:0] req_addr_i,
    input  logic [DRP_DW*NREQ-1:0] req_di_i,
    output logic [NREQ-1:0]        ack_o,
    output logic [DRP_DW-1:0]      rdata_o,
    output logic                   err_o,
    output logic                   drp_den_o,
    output logic                   drp_dwe_o,
    output logic [DRP_AW-1:0]      drp_daddr_o,
    output logic [DRP_DW-1:0]      drp_di_o,
    input  logic [DRP_DW-1:0]      drp_do_i,
    input  logic                   drp_drdy_i
);

    localparam int PW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYC < 1) begin : g_paramCheck
        $error("xadc_drp_arbiter: NREQ must be 2..8 and TIMEOUT_CYC >= 1");
    end

    drp_state_e        state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     idx_q, idx_d;
    logic              dwe_q, dwe_d;
    logic [DRP_AW-1:0] daddr_q, daddr_d;
    logic [DRP_DW-1:0] di_q, di_d;
    logic              den_q, den_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic [DRP_DW-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [PW-1:0]     pickIdx;
    logic              pickValid;
    logic              selWe;
    logic [DRP_AW-1:0] selAddr;
    logic [DRP_DW-1:0] selDi;
    logic [PW-1:0]     nextPtr;

`ifdef XADC_DRP_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT_CYC + 1) < 6) ? 6 : $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] cnt_q, cnt_d;
`endif

    xadc_rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .idx_o   (pickIdx),
        .valid_o (pickValid)
    );

    always_comb begin
        selWe   = 1'b0;
        selAddr = '0;
        selDi   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pickIdx == PW'(i)) begin
                selWe   = req_we_i[i];
                selAddr = req_addr_i[i*DRP_AW +: DRP_AW];
                selDi   = req_di_i[i*DRP_DW +: DRP_DW];
            end
        end
    end

    assign nextPtr = (idx_q == PW'(NREQ - 1)) ? '0 : idx_q + PW'(1);

    // Request fields are captured only in IDLE; WAIT works purely from the latched copy.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        dwe_d   = dwe_q;
        daddr_d = daddr_q;
        di_d    = di_q;
        den_d   = 1'b0;
        ack_d   = '0;
        rdata_d = rdata_q;
        err_d   = 1'b0;
`ifdef XADC_DRP_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pickValid) begin
                    idx_d   = pickIdx;
                    dwe_d   = selWe;
                    daddr_d = selAddr;
                    di_d    = selDi;
                    den_d   = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
`ifdef XADC_DRP_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            ST_WAIT: begin
                if (drp_drdy_i) begin
                    if (!dwe_q) begin
                        rdata_d = drp_do_i;
                    end
                    ack_d[idx_q] = 1'b1;
                    ptr_d        = nextPtr;
                    state_d      = ST_GAP;
                end
`ifdef XADC_DRP_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                    ack_d[idx_q] = 1'b1;
                    err_d        = 1'b1;
                    rdata_d      = XADC_TIMEOUT_DATA;
                    ptr_d        = nextPtr;
                    state_d      = ST_GAP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
`endif
            end
            ST_GAP: begin
                if (!drp_drdy_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            dwe_q   <= 1'b0;
            daddr_q <= '0;
            di_q    <= '0;
            den_q   <= 1'b0;
            ack_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            dwe_q   <= dwe_d;
            daddr_q <= daddr_d;
            di_q    <= di_d;
            den_q   <= den_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

`ifdef XADC_DRP_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign ack_o       = ack_q;
    assign rdata_o     = rdata_q;
    assign err_o       = err_q;
    assign drp_den_o   = den_q;
    assign drp_dwe_o   = dwe_q;
    assign drp_daddr_o = daddr_q;
    assign drp_di_o    = di_q;

endmodule

// File: tb/tb_xadc_drp_arbiter.sv
// Scoreboard bench for xadc_drp_arbiter with a behavioural XADC DRP responder.
// Define XADC_DRP_TIMEOUT_EN to also exercise the stalled-transaction abort.
module tb_xadc_drp_arbiter;
    import xadc_drp_pkg::*;

    localparam int NREQ = 3;
    localparam logic [6:0] SILENT_ADDR = 7'h7F;

    typedef struct {
        logic        we;
        logic [6:0]  addr;
        logic [15:0] di;
    } denExp_t;

    typedef struct {
        int          idx;
        logic [15:0] rdata;
        logic        err;
    } ackExp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NREQ-1:0]    reqV  = '0;
    logic [NREQ-1:0]    weV   = '0;
    logic [7*NREQ-1:0]  addrV = '0;
    logic [16*NREQ-1:0] diV   = '0;

    logic [NREQ-1:0] ackO;
    logic [15:0]     rdataO;
    logic            errO;
    logic            drpDen;
    logic            drpDwe;
    logic [6:0]      drpDaddr;
    logic [15:0]     drpDi;
    logic [15:0]     drpDo;
    logic            drpDrdy;

    int total = 0;
    int bad   = 0;

    denExp_t denQ[$];
    ackExp_t ackQ[$];
    logic [15:0] expRdata = '0;

    int modelLat  = 3;
    int modelHold = 1;
    int waitCnt;
    int holdCnt;
    logic [6:0] pendAddr;

    logic    denPrev = 1'b0;
    logic    drdyAtEdge;
    logic [6:0] lastAddr = '0;
    denExp_t dPop;
    ackExp_t aPop;

    xadc_drp_arbiter #(.NREQ(NREQ), .TIMEOUT_CYC(63)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (reqV),
        .req_we_i    (weV),
        .req_addr_i  (addrV),
        .req_di_i    (diV),
        .ack_o       (ackO),
        .rdata_o     (rdataO),
        .err_o       (errO),
        .drp_den_o   (drpDen),
        .drp_dwe_o   (drpDwe),
        .drp_daddr_o (drpDaddr),
        .drp_di_o    (drpDi),
        .drp_do_i    (drpDo),
        .drp_drdy_i  (drpDrdy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] romData(input logic [6:0] a);
        case (a)
            7'h00:   romData = 16'h9770;
            7'h01:   romData = 16'hA5C3;
            7'h02:   romData = 16'h5A3C;
            7'h40:   romData = 16'h0123;
            default: romData = {9'h0, a};
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // DRP responder: answers modelLat cycles after DEN, holds DRDY modelHold cycles.
    always @(posedge clk) begin
        if (rst) begin
            waitCnt = 0;
            holdCnt = 0;
            drpDrdy <= 1'b0;
            drpDo   <= '0;
        end else begin
            if (holdCnt > 0) begin
                holdCnt--;
                if (holdCnt == 0) drpDrdy <= 1'b0;
            end
            if (waitCnt > 0) begin
                waitCnt--;
                if (waitCnt == 0) begin
                    drpDrdy <= 1'b1;
                    drpDo   <= romData(pendAddr);
                    holdCnt = modelHold;
                end
            end
            if (drpDen && drpDaddr != SILENT_ADDR) begin
                waitCnt  = modelLat;
                pendAddr = drpDaddr;
            end
        end
    end

    always @(posedge clk) drdyAtEdge <= drpDrdy;

    // Monitor: pops the expected DEN and ack records as the DUT produces them.
    always @(negedge clk) begin
        if (!rst) begin
            if (drpDen) begin
                checkOutput("denDuringDrdy", 32'(drpDrdy), 32'(0));
                checkOutput("denOneCycle", 32'(denPrev), 32'(0));
                checkOutput("denExpected", 32'(denQ.size() != 0), 32'(1));
                if (denQ.size() != 0) begin
                    dPop = denQ.pop_front();
                    checkOutput("dwe", 32'(drpDwe), 32'(dPop.we));
                    checkOutput("daddr", 32'(drpDaddr), 32'(dPop.addr));
                    checkOutput("di", 32'(drpDi), 32'(dPop.di));
                    lastAddr = dPop.addr;
                end
            end
            if (ackO != '0) begin
                checkOutput("ackExpected", 32'(ackQ.size() != 0), 32'(1));
                if (ackQ.size() != 0) begin
                    aPop = ackQ.pop_front();
                    checkOutput("ackVec", 32'(ackO), 32'(1) << aPop.idx);
                    checkOutput("rdata", 32'(rdataO), 32'(aPop.rdata));
                    checkOutput("err", 32'(errO), 32'(aPop.err));
                    checkOutput("daddrHeld", 32'(drpDaddr), 32'(lastAddr));
                    if (!aPop.err) checkOutput("ackAfterDrdy", 32'(drdyAtEdge), 32'(1));
                end
            end
        end
        denPrev = drpDen;
    end

    task automatic setReq(input int idx, input logic we, input logic [6:0] addr, input logic [15:0] di);
        weV[idx]             = we;
        addrV[idx*7 +: 7]    = addr;
        diV[idx*16 +: 16]    = di;
        reqV[idx]            = 1'b1;
    endtask

    task automatic applyStimulus(input int idx, input logic we, input logic [6:0] addr,
                                 input logic [15:0] di, input logic [15:0] rd, input logic er);
        denExp_t d;
        ackExp_t a;
        d.we = we; d.addr = addr; d.di = di;
        denQ.push_back(d);
        if (!we) expRdata = rd;
        a.idx = idx; a.rdata = expRdata; a.err = er;
        ackQ.push_back(a);
        setReq(idx, we, addr, di);
    endtask

    task automatic runUntilIdle(input int budget);
        bit done = 0;
        for (int n = 0; n < budget && !done; n++) begin
            @(posedge clk); #1;
            for (int i = 0; i < NREQ; i++) if (ackO[i]) reqV[i] = 1'b0;
            if (ackQ.size() == 0 && denQ.size() == 0) done = 1;
        end
        if (!done) checkOutput("runBudget", 32'(ackQ.size()), 32'(0));
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic waitDen(input int budget);
        bit seen = 0;
        for (int n = 0; n < budget && !seen; n++) begin
            @(posedge clk); #1;
            if (drpDen) seen = 1;
        end
        if (!seen) checkOutput("denBudget", 32'(drpDen), 32'(1));
    endtask

    task automatic doReset();
        reqV = '0;
        rst  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        expRdata = '0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstAck", 32'(ackO), 32'(0));
        checkOutput("rstRdata", 32'(rdataO), 32'(0));
        checkOutput("rstErr", 32'(errO), 32'(0));
        checkOutput("rstDen", 32'(drpDen), 32'(0));
        checkOutput("rstDwe", 32'(drpDwe), 32'(0));
        checkOutput("rstDaddr", 32'(drpDaddr), 32'(0));
        checkOutput("rstDi", 32'(drpDi), 32'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        $display("[TB] single read");
        applyStimulus(0, 1'b0, XADC_ADDR_TEMP, 16'h0000, 16'h9770, 1'b0);
        @(posedge clk); #1;
        checkOutput("denLatency", 32'(drpDen), 32'(1));
        addrV[6:0] = 7'h55;
        diV[15:0]  = 16'hBEEF;
        weV[0]     = 1'b1;
        runUntilIdle(40);

        $display("[TB] simultaneous requests");
        doReset();
        applyStimulus(0, 1'b0, XADC_ADDR_VCCINT, 16'h0000, 16'hA5C3, 1'b0);
        applyStimulus(1, 1'b0, XADC_ADDR_VCCAUX, 16'h0000, 16'h5A3C, 1'b0);
        applyStimulus(2, 1'b0, XADC_ADDR_CFG0,   16'h0000, 16'h0123, 1'b0);
        runUntilIdle(100);
        applyStimulus(0, 1'b0, XADC_ADDR_TEMP,   16'h0000, 16'h9770, 1'b0);
        applyStimulus(2, 1'b0, XADC_ADDR_VCCAUX, 16'h0000, 16'h5A3C, 1'b0);
        runUntilIdle(80);

        $display("[TB] write");
        applyStimulus(2, 1'b1, XADC_ADDR_CFG1, 16'h2000, 16'h0000, 1'b0);
        runUntilIdle(40);

        $display("[TB] long drdy");
        modelHold = 4;
        applyStimulus(0, 1'b0, XADC_ADDR_TEMP,   16'h0000, 16'h9770, 1'b0);
        applyStimulus(1, 1'b0, XADC_ADDR_VCCINT, 16'h0000, 16'hA5C3, 1'b0);
        runUntilIdle(80);
        modelHold = 1;

        $display("[TB] reset during wait");
        modelLat = 10;
        begin
            denExp_t d;
            d.we = 1'b0; d.addr = XADC_ADDR_TEMP; d.di = 16'h0000;
            denQ.push_back(d);
        end
        setReq(0, 1'b0, XADC_ADDR_TEMP, 16'h0000);
        waitDen(20);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("midRstDen", 32'(drpDen), 32'(0));
        checkOutput("midRstAck", 32'(ackO), 32'(0));
        checkOutput("midRstRdata", 32'(rdataO), 32'(0));
        rst = 1'b0;
        expRdata = '0;
        applyStimulus(0, 1'b0, XADC_ADDR_TEMP, 16'h0000, 16'h9770, 1'b0);
        @(posedge clk); #1;
        checkOutput("reissueDen", 32'(drpDen), 32'(1));
        runUntilIdle(60);
        modelLat = 3;

`ifdef XADC_DRP_TIMEOUT_EN
        $display("[TB] timeout");
        applyStimulus(1, 1'b0, SILENT_ADDR,      16'h0000, 16'hFFFF, 1'b1);
        applyStimulus(2, 1'b0, XADC_ADDR_VCCINT, 16'h0000, 16'hA5C3, 1'b0);
        runUntilIdle(300);
`endif

        repeat (4) @(posedge clk);
        #1;
        checkOutput("queuesEmpty", 32'(denQ.size() + ackQ.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
